// File: rtl/nanomips_pkg.sv
// Shared constants and FSM state encoding for the register spill/fill engine.
`timescale 1ns/1ps
package nanomips_pkg;

  localparam int unsigned NUM_CORE  = 8;
  localparam int unsigned SUPER_IDX = NUM_CORE;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RFWR = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spill_addr_gen.sv
// Memory address for transfer idx: base plus index, wrapping modulo 256.
`timescale 1ns/1ps
module spill_addr_gen #(
  parameter int unsigned IDX_W = 4
) (
  input  logic [7:0]       i_base,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_addr
);

  assign o_addr = i_base + 8'(i_idx);

endmodule

// File: rtl/reg_spill.sv
// Moves core registers plus the super register between the register file and memory.
// Outputs are decoded from the registered state; spill write data passes straight from the RF.
`timescale 1ns/1ps
module reg_spill #(
  parameter int unsigned NUM_CORE = nanomips_pkg::NUM_CORE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] base_addr,
  output logic       busy,
  output logic       done,
  output logic [2:0] rf_rs,
  input  logic [7:0] rf_rs_data,
  input  logic [7:0] rf_super_data,
  output logic [2:0] rf_rt,
  output logic [7:0] rf_data_in,
  output logic       rf_write_enable,
  output logic       rf_write_direction,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  import nanomips_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_CORE + 1);

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_mode, w_mode_nxt;
  logic [7:0]       r_base, w_base_nxt;
  logic [7:0]       r_rdata, w_rdata_nxt;

  logic [7:0]       w_addr;
  logic             w_last;
  logic             w_spill_xfer;

  spill_addr_gen #(.IDX_W(IDX_W)) u_addr_gen (
    .i_base (r_base),
    .i_idx  (r_idx),
    .o_addr (w_addr)
  );

  assign w_last       = (r_idx == IDX_W'(NUM_CORE));
  assign w_spill_xfer = (r_state == XFER) && !r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_base  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_base  <= w_base_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Next-state: mem_ack only matters in XFER, where mem_req is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_base_nxt  = r_base;
    w_rdata_nxt = r_rdata;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_nxt  = mode;
          w_base_nxt  = base_addr;
          w_idx_nxt   = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (mem_ack) begin
          if (r_mode) begin
            w_rdata_nxt = mem_rdata;
            w_state_nxt = RFWR;
          end else if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      RFWR: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = XFER;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: everything idles at zero outside the state that drives it.
  always_comb begin
    busy               = (r_state != IDLE);
    done               = (r_state == DONE);
    mem_req            = (r_state == XFER);
    mem_we             = w_spill_xfer;
    mem_addr           = 8'd0;
    mem_wdata          = 8'd0;
    rf_rs              = 3'd0;
    rf_rt              = 3'd0;
    rf_data_in         = 8'd0;
    rf_write_enable    = 1'b0;
    rf_write_direction = 1'b0;
    if (r_state == XFER) begin
      mem_addr = w_addr;
    end
    if (w_spill_xfer) begin
      rf_rs     = 3'(r_idx);
      mem_wdata = w_last ? rf_super_data : rf_rs_data;
    end
    if (r_state == RFWR) begin
      rf_write_enable    = 1'b1;
      rf_rt              = 3'(r_idx);
      rf_data_in         = r_rdata;
      rf_write_direction = !w_last;
    end
  end

endmodule

// File: tb/tb_reg_spill.sv
// Directed bench for reg_spill with a behavioural register file and memory.
`timescale 1ns/1ps
module tb_reg_spill;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] base_addr;
  logic       busy;
  logic       done;
  logic [2:0] rf_rs;
  logic [7:0] rf_rs_data;
  logic [7:0] rf_super_data;
  logic [2:0] rf_rt;
  logic [7:0] rf_data_in;
  logic       rf_write_enable;
  logic       rf_write_direction;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int errors = 0;
  int checks = 0;

  logic [7:0] core [8];
  logic [7:0] super_r;
  logic [7:0] mem [256];

  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  bit         log_we[$];

  reg_spill #(.NUM_CORE(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .mode               (mode),
    .base_addr          (base_addr),
    .busy               (busy),
    .done               (done),
    .rf_rs              (rf_rs),
    .rf_rs_data         (rf_rs_data),
    .rf_super_data      (rf_super_data),
    .rf_rt              (rf_rt),
    .rf_data_in         (rf_data_in),
    .rf_write_enable    (rf_write_enable),
    .rf_write_direction (rf_write_direction),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rs_data    = core[rf_rs];
  assign rf_super_data = super_r;
  assign mem_rdata     = mem[mem_addr];

  // Register file, memory and handshake log models.
  always @(posedge clk) begin
    if (rf_write_enable) begin
      if (rf_write_direction) core[rf_rt] <= rf_data_in;
      else                    super_r     <= rf_data_in;
    end
    if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_we.push_back(mem_we);
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_we.delete();
  endtask

  task automatic preload_rf(input logic [7:0] core_base, input logic [7:0] sup);
    @(negedge clk);
    for (int i = 0; i < 8; i++) core[i] <= 8'(core_base + 8'(i));
    super_r <= sup;
    @(negedge clk);
  endtask

  task automatic preload_mem(input logic [7:0] addr0, input logic [7:0] data0);
    @(negedge clk);
    for (int i = 0; i < 9; i++) mem[8'(addr0 + 8'(i))] <= 8'(data0 + 8'(i));
    @(negedge clk);
  endtask

  // Pulses start for one cycle; returns at the negedge of the first busy cycle.
  task automatic kick(input logic m, input logic [7:0] b);
    @(negedge clk);
    mode      = m;
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    rst_n = 1'b0; start = 1'b1; mode = 1'b0; base_addr = 8'h33; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    outs = {busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_write_enable,
            rf_write_direction, rf_rs, rf_rt, rf_data_in};
    checks++;
    if (outs !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b mem_req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_spill();
    int cyc;
    preload_rf(8'h10, 8'hA5);
    clear_log();
    kick(1'b0, 8'h20);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL spill_first_cycle: busy=%b req=%b we=%b expected 1 1 1", busy, mem_req, mem_we);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL spill_done_cycle: got %0d expected 10", cyc);
    end
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL spill_count: got %0d expected 9", log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        logic [16:0] got, exp;
        got = {log_we[i], log_addr[i], log_data[i]};
        exp = {1'b1, 8'(8'h20 + 8'(i)), (i == 8) ? 8'hA5 : 8'(8'h10 + 8'(i))};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL spill_xfer%0d: got %h expected %h", i, got, exp);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL spill_after_done: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_fill();
    int cyc;
    preload_rf(8'h00, 8'h00);
    preload_mem(8'h40, 8'h80);
    clear_log();
    kick(1'b1, 8'h40);
    wait_done(cyc);
    checks++;
    if (cyc !== 19) begin
      errors++;
      $display("FAIL fill_done_cycle: got %0d expected 19", cyc);
    end
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL fill_count: got %0d expected 9", log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if ({log_we[i], log_addr[i]} !== {1'b0, 8'(8'h40 + 8'(i))}) begin
          errors++;
          $display("FAIL fill_read%0d: got we=%b addr=%h expected we=0 addr=%h",
                   i, log_we[i], log_addr[i], 8'(8'h40 + 8'(i)));
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (core[i] !== 8'(8'h80 + 8'(i))) begin
        errors++;
        $display("FAIL fill_core%0d: got %h expected %h", i, core[i], 8'(8'h80 + 8'(i)));
      end
    end
    checks++;
    if (super_r !== 8'h88) begin
      errors++;
      $display("FAIL fill_super: got %h expected 88", super_r);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    preload_rf(8'h10, 8'hA5);
    clear_log();
    kick(1'b0, 8'hFC);
    wait_done(cyc);
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 9", log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_addr[i] !== 8'(8'hFC + 8'(i))) begin
          errors++;
          $display("FAIL wrap_addr%0d: got %h expected %h", i, log_addr[i], 8'(8'hFC + 8'(i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    preload_rf(8'h10, 8'hA5);
    clear_log();
    kick(1'b0, 8'h60);
    c = 1;
    forever begin
      mem_ack = !(c >= 3 && c <= 5);
      if (c >= 3 && c <= 6) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h62, 8'h12}) begin
          errors++;
          $display("FAIL bp_hold_c%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 62 12",
                   c, mem_req, mem_we, mem_addr, mem_wdata);
        end
      end
      if (done === 1'b1 || c >= 60) break;
      @(negedge clk);
      c++;
    end
    mem_ack = 1'b1;
    checks++;
    if (c !== 13) begin
      errors++;
      $display("FAIL bp_done_cycle: got %0d expected 13", c);
    end
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL bp_count: got %0d expected 9", log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        logic [15:0] exp;
        exp = {8'(8'h60 + 8'(i)), (i == 8) ? 8'hA5 : 8'(8'h10 + 8'(i))};
        checks++;
        if ({log_addr[i], log_data[i]} !== exp) begin
          errors++;
          $display("FAIL bp_xfer%0d: got %h%h expected %h", i, log_addr[i], log_data[i], exp);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int dcnt, dcyc;
    dcnt = 0;
    dcyc = 0;
    preload_rf(8'h10, 8'hA5);
    clear_log();
    @(negedge clk);
    mode = 1'b0; base_addr = 8'h50; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 4 || c == 10);
      if (done === 1'b1) begin
        dcnt++;
        dcyc = c;
      end
    end
    start = 1'b0;
    checks++;
    if (dcnt !== 1 || dcyc !== 10) begin
      errors++;
      $display("FAIL busy_start_done: got %0d pulses at cycle %0d expected 1 at 10", dcnt, dcyc);
    end
    checks++;
    if (log_addr.size() !== 9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_xfers: got %0d xfers busy=%b expected 9 busy=0", log_addr.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [43:0] outs;
    preload_rf(8'h10, 8'hA5);
    preload_mem(8'h40, 8'h80);
    clear_log();
    kick(1'b1, 8'h40);
    repeat (10) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h45) begin
      errors++;
      $display("FAIL rmid_pre: got req=%b addr=%h expected 1 45", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    outs = {busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_write_enable,
            rf_write_direction, rf_rs, rf_rt, rf_data_in};
    checks++;
    if (outs !== 44'd0) begin
      errors++;
      $display("FAIL rmid_outputs: got %h expected 0", outs);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i < 5) ? 8'(8'h80 + 8'(i)) : 8'(8'h10 + 8'(i));
      checks++;
      if (core[i] !== exp) begin
        errors++;
        $display("FAIL rmid_core%0d: got %h expected %h", i, core[i], exp);
      end
    end
    checks++;
    if (super_r !== 8'hA5 || log_addr.size() !== 5) begin
      errors++;
      $display("FAIL rmid_super_log: got super=%h reads=%0d expected A5 5", super_r, log_addr.size());
    end
    clear_log();
    kick(1'b0, 8'h30);
    wait_done(cyc);
    checks++;
    if (cyc !== 10 || log_addr.size() !== 9) begin
      errors++;
      $display("FAIL rmid_restart: got cyc=%0d xfers=%0d expected 10 9", cyc, log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 8'h30 || log_data[0] !== 8'h80) begin
        errors++;
        $display("FAIL rmid_restart_first: got %h/%h expected 30/80", log_addr[0], log_data[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) core[i] = 8'h00;
    super_r = 8'h00;
    start = 1'b0; mode = 1'b0; base_addr = 8'h00; mem_ack = 1'b1; rst_n = 1'b0;
    test_reset();
    test_spill();
    test_fill();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
